icache_dm: RTL and testbench



---
 rtl/icache_dm.sv | 107 ++++++++++
 tb/tb_icache_dm.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/icache_dm.sv
// rtl/icache_dm.sv - direct-mapped blocking instruction cache with word-serial line refill
module icache_dm #(
  parameter int INDEX_W  = 6,
  parameter int OFFSET_W = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] if_pc_i,
  input  logic        if_valid_req_i,
  input  logic        fc_Icache_flush_i,
  output logic [31:0] Icache_inst_o,
  output logic        Icache_inst_valid_o,
  output logic        Icache_stall_flag_o,
  output logic        Icache_mem_req_o,
  output logic [31:0] Icache_mem_addr_o,
  input  logic        mem_Icache_ack_i,
  input  logic [31:0] mem_Icache_data_i
);
  localparam int LINES  = 1 << INDEX_W;
  localparam int WORD_W = OFFSET_W - 2;
  localparam int WPL    = 1 << WORD_W;
  localparam int TAG_W  = 32 - INDEX_W - OFFSET_W;

  typedef enum logic {IDLE, REFILL} state_t;

  state_t            state;
  logic              flush_pending;
  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [31:0]       data_q [LINES][WPL];

  logic [TAG_W-1:0]   pc_tag;
  logic [INDEX_W-1:0] pc_index;
  logic [WORD_W-1:0]  pc_word;
  logic [TAG_W-1:0]   refill_tag;
  logic [INDEX_W-1:0] refill_index;
  logic [WORD_W-1:0]  refill_word;
  logic               hit;
  logic               miss;
  logic               last_word;
  logic               unused_pc_bits;

  assign pc_tag         = if_pc_i[31:INDEX_W+OFFSET_W];
  assign pc_index       = if_pc_i[INDEX_W+OFFSET_W-1:OFFSET_W];
  assign pc_word        = if_pc_i[OFFSET_W-1:2];
  assign unused_pc_bits = &{1'b0, if_pc_i[1:0]};

  // The refill address starts line-aligned, so its word bits double as the fill counter.
  assign refill_tag   = Icache_mem_addr_o[31:INDEX_W+OFFSET_W];
  assign refill_index = Icache_mem_addr_o[INDEX_W+OFFSET_W-1:OFFSET_W];
  assign refill_word  = Icache_mem_addr_o[OFFSET_W-1:2];
  assign last_word    = &refill_word;

  // A flush in the same cycle forces the lookup to miss.
  assign hit  = if_valid_req_i & valid_q[pc_index] & (tag_q[pc_index] == pc_tag) & ~fc_Icache_flush_i;
  assign miss = if_valid_req_i & ~hit;

  assign Icache_stall_flag_o = (state != IDLE) | miss | ((state == IDLE) & flush_pending);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      flush_pending       <= 1'b0;
      valid_q             <= '0;
      Icache_inst_o       <= '0;
      Icache_inst_valid_o <= 1'b0;
      Icache_mem_req_o    <= 1'b0;
      Icache_mem_addr_o   <= '0;
    end else begin
      case (state)
        IDLE: begin
          Icache_inst_valid_o <= 1'b0;
          flush_pending       <= 1'b0;
          if (fc_Icache_flush_i || flush_pending) valid_q <= '0;
          if (!flush_pending && miss) begin
            Icache_mem_req_o  <= 1'b1;
            Icache_mem_addr_o <= {if_pc_i[31:OFFSET_W], {OFFSET_W{1'b0}}};
            state             <= REFILL;
          end else if (!flush_pending && hit) begin
            Icache_inst_o       <= data_q[pc_index][pc_word];
            Icache_inst_valid_o <= 1'b1;
          end
        end
        REFILL: begin
          Icache_inst_valid_o <= 1'b0;
          if (fc_Icache_flush_i) flush_pending <= 1'b1;
          if (mem_Icache_ack_i) begin
            Icache_mem_addr_o <= Icache_mem_addr_o + 32'd4;
            if (last_word) begin
              valid_q[refill_index] <= 1'b1;
              Icache_mem_req_o      <= 1'b0;
              state                 <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == REFILL && mem_Icache_ack_i) begin
      data_q[refill_index][refill_word] <= mem_Icache_data_i;
      if (last_word) tag_q[refill_index] <= refill_tag;
    end
  end
endmodule

// File: tb/tb_icache_dm.sv
// tb/tb_icache_dm.sv - directed self-checking bench for icache_dm
module tb_icache_dm;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] if_pc_i = '0;
  logic        if_valid_req_i = 1'b0;
  logic        fc_Icache_flush_i = 1'b0;
  logic [31:0] Icache_inst_o;
  logic        Icache_inst_valid_o;
  logic        Icache_stall_flag_o;
  logic        Icache_mem_req_o;
  logic [31:0] Icache_mem_addr_o;
  logic        mem_Icache_ack_i = 1'b0;
  logic [31:0] mem_Icache_data_i = '0;

  int errors = 0;
  int checks = 0;
  int ack_wait = 0;
  int wait_cnt = 0;
  logic [31:0] acked[$];

  icache_dm dut (
    .clk(clk), .rst_n(rst_n), .if_pc_i(if_pc_i), .if_valid_req_i(if_valid_req_i),
    .fc_Icache_flush_i(fc_Icache_flush_i), .Icache_inst_o(Icache_inst_o),
    .Icache_inst_valid_o(Icache_inst_valid_o), .Icache_stall_flag_o(Icache_stall_flag_o),
    .Icache_mem_req_o(Icache_mem_req_o), .Icache_mem_addr_o(Icache_mem_addr_o),
    .mem_Icache_ack_i(mem_Icache_ack_i), .mem_Icache_data_i(mem_Icache_data_i)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memval(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, ~a[15:0]};
  endfunction

  // Advance one clock; memory answers each requested word after ack_wait idle cycles.
  task automatic step();
    @(posedge clk);
    #1;
    if (Icache_mem_req_o) begin
      if (wait_cnt >= ack_wait) begin
        mem_Icache_ack_i = 1'b1; mem_Icache_data_i = memval(Icache_mem_addr_o); wait_cnt = 0;
      end else begin
        mem_Icache_ack_i = 1'b0; mem_Icache_data_i = '0; wait_cnt++;
      end
    end else begin
      mem_Icache_ack_i = 1'b0; wait_cnt = 0;
    end
  endtask

  // Runs while stall is high, collecting stall cycles, req cycles, stray valids and acked addresses.
  task automatic run_refill(input int max, input int switch_at, input logic [31:0] switch_pc,
                            input int flush_at, output int stalls, output int reqcyc, output int vld_seen);
    acked.delete(); stalls = 0; reqcyc = 0; vld_seen = 0;
    for (int i = 0; i < max; i++) begin
      if (i == switch_at) if_pc_i = switch_pc;
      fc_Icache_flush_i = (i == flush_at);
      #1;
      if (!Icache_stall_flag_o) break;
      stalls++;
      if (i > 0 && Icache_inst_valid_o) vld_seen++;
      if (Icache_mem_req_o) begin
        reqcyc++;
        if (mem_Icache_ack_i) acked.push_back(Icache_mem_addr_o);
      end
      step();
    end
    fc_Icache_flush_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; step(); step();
    checks++; if (Icache_inst_o !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h expected 0", Icache_inst_o); end
    checks++; if (Icache_inst_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", Icache_inst_valid_o); end
    checks++; if (Icache_mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", Icache_mem_req_o); end
    checks++; if (Icache_mem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", Icache_mem_addr_o); end
    checks++; if (Icache_stall_flag_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", Icache_stall_flag_o); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_cold_miss();
    int st, rc, vs;
    ack_wait = 0; if_pc_i = 32'h0; if_valid_req_i = 1'b1;
    run_refill(40, -1, 0, -1, st, rc, vs);
    checks++; if (st !== 5) begin errors++; $display("FAIL cold_stalls: got %0d expected 5", st); end
    checks++; if (rc !== 4) begin errors++; $display("FAIL cold_req_cycles: got %0d expected 4", rc); end
    checks++; if (vs !== 0) begin errors++; $display("FAIL cold_valid_in_refill: got %0d expected 0", vs); end
    checks++; if (acked.size() !== 4) begin errors++; $display("FAIL cold_words: got %0d expected 4", acked.size()); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (acked[k] !== 32'(4 * k)) begin errors++; $display("FAIL cold_addr%0d: got %h expected %h", k, acked[k], 32'(4 * k)); end
    end
    step();
    checks++; if (Icache_inst_valid_o !== 1'b1) begin errors++; $display("FAIL cold_hit_valid: got %b expected 1", Icache_inst_valid_o); end
    checks++; if (Icache_inst_o !== memval(32'h0)) begin errors++; $display("FAIL cold_hit_data: got %h expected %h", Icache_inst_o, memval(32'h0)); end
  endtask

  task automatic test_seq_hits();
    logic [31:0] seq [3];
    seq = '{32'h4, 32'h8, 32'hC};
    for (int k = 0; k < 3; k++) begin
      if_pc_i = seq[k]; #1;
      checks++; if (Icache_stall_flag_o !== 1'b0) begin errors++; $display("FAIL hit_stall pc=%h: got %b expected 0", seq[k], Icache_stall_flag_o); end
      step();
      checks++; if (Icache_inst_valid_o !== 1'b1 || Icache_inst_o !== memval(seq[k])) begin
        errors++; $display("FAIL hit_data pc=%h: got %b/%h expected 1/%h", seq[k], Icache_inst_valid_o, Icache_inst_o, memval(seq[k])); end
    end
    if_valid_req_i = 1'b0; mem_Icache_ack_i = 1'b1; mem_Icache_data_i = 32'hBAD0BAD0; #1;
    checks++; if (Icache_stall_flag_o !== 1'b0) begin errors++; $display("FAIL noreq_stall: got %b expected 0", Icache_stall_flag_o); end
    step();
    checks++; if (Icache_inst_valid_o !== 1'b0) begin errors++; $display("FAIL noreq_valid: got %b expected 0", Icache_inst_valid_o); end
    if_valid_req_i = 1'b1; if_pc_i = 32'h4; #1;
    checks++; if (Icache_stall_flag_o !== 1'b0) begin errors++; $display("FAIL rehit_stall: got %b expected 0", Icache_stall_flag_o); end
    step();
    checks++; if (Icache_inst_o !== memval(32'h4)) begin errors++; $display("FAIL rehit_data: got %h expected %h", Icache_inst_o, memval(32'h4)); end
  endtask

  task automatic test_conflict();
    int st, rc, vs;
    ack_wait = 2; if_pc_i = 32'h400;
    run_refill(80, -1, 0, -1, st, rc, vs);
    checks++; if (st !== 13) begin errors++; $display("FAIL conflict_stalls: got %0d expected 13", st); end
    checks++; if (rc !== 12) begin errors++; $display("FAIL conflict_req_held: got %0d expected 12", rc); end
    checks++; if (acked.size() !== 4 || acked[3] !== 32'h40C) begin errors++; $display("FAIL conflict_last_addr: got %h expected 40c", acked[3]); end
    step();
    checks++; if (Icache_inst_o !== memval(32'h400)) begin errors++; $display("FAIL conflict_data: got %h expected %h", Icache_inst_o, memval(32'h400)); end
    ack_wait = 0; if_pc_i = 32'h0; #1;
    checks++; if (Icache_stall_flag_o !== 1'b1) begin errors++; $display("FAIL evicted_miss: got %b expected 1", Icache_stall_flag_o); end
    run_refill(40, -1, 0, -1, st, rc, vs);
    checks++; if (st !== 5) begin errors++; $display("FAIL refill0_stalls: got %0d expected 5", st); end
    step();
    checks++; if (Icache_inst_o !== memval(32'h0)) begin errors++; $display("FAIL refill0_data: got %h expected %h", Icache_inst_o, memval(32'h0)); end
  endtask

  task automatic test_jump();
    int st, rc, vs;
    if_pc_i = 32'h100;
    run_refill(60, 2, 32'h2000, -1, st, rc, vs);
    checks++; if (st !== 10) begin errors++; $display("FAIL jump_stalls: got %0d expected 10", st); end
    checks++; if (vs !== 0) begin errors++; $display("FAIL jump_valid_in_refill: got %0d expected 0", vs); end
    checks++; if (acked.size() !== 8) begin errors++; $display("FAIL jump_words: got %0d expected 8", acked.size()); end
    checks++; if (acked[3] !== 32'h10C || acked[4] !== 32'h2000) begin errors++; $display("FAIL jump_addrs: got %h,%h expected 10c,2000", acked[3], acked[4]); end
    step();
    checks++; if (Icache_inst_o !== memval(32'h2000)) begin errors++; $display("FAIL jump_data: got %h expected %h", Icache_inst_o, memval(32'h2000)); end
    if_pc_i = 32'h100; #1;
    checks++; if (Icache_stall_flag_o !== 1'b0) begin errors++; $display("FAIL jump_first_line_stall: got %b expected 0", Icache_stall_flag_o); end
    step();
    checks++; if (Icache_inst_o !== memval(32'h100)) begin errors++; $display("FAIL jump_first_line_data: got %h expected %h", Icache_inst_o, memval(32'h100)); end
  endtask

  task automatic test_flush_idle();
    int st, rc, vs;
    if_valid_req_i = 1'b0; fc_Icache_flush_i = 1'b1; #1;
    step();
    fc_Icache_flush_i = 1'b0; if_valid_req_i = 1'b1; if_pc_i = 32'h100; #1;
    checks++; if (Icache_stall_flag_o !== 1'b1) begin errors++; $display("FAIL flush_idle_miss: got %b expected 1", Icache_stall_flag_o); end
    run_refill(40, -1, 0, -1, st, rc, vs);
    checks++; if (st !== 5 || acked[0] !== 32'h100) begin errors++; $display("FAIL flush_idle_refill: got %0d/%h expected 5/100", st, acked[0]); end
    step();
    run_refill(40, -1, 0, 0, st, rc, vs);
    checks++; if (st !== 5) begin errors++; $display("FAIL flush_same_cycle_miss: got %0d expected 5", st); end
    step();
    checks++; if (Icache_inst_valid_o !== 1'b1 || Icache_inst_o !== memval(32'h100)) begin
      errors++; $display("FAIL flush_same_cycle_data: got %b/%h expected 1/%h", Icache_inst_valid_o, Icache_inst_o, memval(32'h100)); end
  endtask

  task automatic test_flush_refill();
    int st, rc, vs;
    if_pc_i = 32'h0;
    run_refill(60, -1, 0, 2, st, rc, vs);
    checks++; if (st !== 11) begin errors++; $display("FAIL flush_refill_stalls: got %0d expected 11", st); end
    checks++; if (acked.size() !== 8 || acked[4] !== 32'h0) begin errors++; $display("FAIL flush_refill_refetch: got %0d/%h expected 8/0", acked.size(), acked[4]); end
    checks++; if (vs !== 0) begin errors++; $display("FAIL flush_refill_valid: got %0d expected 0", vs); end
    step();
    checks++; if (Icache_inst_o !== memval(32'h0)) begin errors++; $display("FAIL flush_refill_data: got %h expected %h", Icache_inst_o, memval(32'h0)); end
  endtask

  task automatic test_reset_mid();
    int st, rc, vs;
    if_pc_i = 32'h300;
    run_refill(3, -1, 0, -1, st, rc, vs);
    rst_n = 1'b0; #1;
    checks++; if (Icache_mem_req_o !== 1'b0) begin errors++; $display("FAIL rst_mid_req: got %b expected 0", Icache_mem_req_o); end
    checks++; if (Icache_inst_valid_o !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b expected 0", Icache_inst_valid_o); end
    step();
    rst_n = 1'b1; #1;
    checks++; if (Icache_stall_flag_o !== 1'b1) begin errors++; $display("FAIL rst_mid_miss: got %b expected 1", Icache_stall_flag_o); end
    run_refill(40, -1, 0, -1, st, rc, vs);
    checks++; if (st !== 5 || acked.size() !== 4 || acked[0] !== 32'h300) begin
      errors++; $display("FAIL rst_mid_refill: got %0d/%0d/%h expected 5/4/300", st, acked.size(), acked[0]); end
    step();
    checks++; if (Icache_inst_o !== memval(32'h300)) begin errors++; $display("FAIL rst_mid_data: got %h expected %h", Icache_inst_o, memval(32'h300)); end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_seq_hits();
    test_conflict();
    test_jump();
    test_flush_idle();
    test_flush_refill();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within 200000 time units");
    $fatal(1, "watchdog");
  end
endmodule
